// File: rtl/trng_postproc.sv
// TRNG post-processing: raw-bit synchroniser, decimating strobe, repetition-count
// health test, von Neumann debiaser and LSB-first word packer with a one-word output buffer.
module trng_postproc #(
    parameter int WORD_W     = 8,
    parameter int SAMPLE_DIV = 1,
    parameter int RCT_CUTOFF = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              raw_bit,
    input  logic              en,
    output logic [WORD_W-1:0] rnd_data,
    output logic              rnd_valid,
    input  logic              rnd_ready,
    output logic              health_fail
);

    localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int BIT_W = $clog2(WORD_W + 1);
    localparam int REP_W = $clog2(RCT_CUTOFF + 1);

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [BIT_W-1:0] BITS_FULL = BIT_W'(WORD_W);
    localparam logic [REP_W-1:0] REP_MAX   = REP_W'(RCT_CUTOFF);

    logic              s1_q, s2_q;
    logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
    logic              pend_q, pend_d;
    logic              b0_q, b0_d;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [WORD_W-1:0] acc_q, acc_d;
    logic              last_q, last_d;
    logic [REP_W-1:0]  rep_cnt_q, rep_cnt_d;
    logic              health_fail_q, health_fail_d;
    logic [WORD_W-1:0] rnd_data_q, rnd_data_d;
    logic              rnd_valid_q, rnd_valid_d;

    logic             strobe;
    logic             rep_match;
    logic [REP_W-1:0] rep_inc;
    logic             trip;
    logic             vn_act;
    logic             emit;
    logic             acc_full;
    logic             load;

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        strobe    = en && (div_cnt_q == DIV_LAST);
        div_cnt_d = div_cnt_q;
        if (!en || strobe) begin
            div_cnt_d = '0;
        end else begin
            div_cnt_d = div_cnt_q + 1'b1;
        end

        // rep_cnt==0 marks "no sample seen since reset", so the first strobe never matches.
        rep_match     = (rep_cnt_q != '0) && (s2_q == last_q);
        rep_inc       = rep_cnt_q + 1'b1;
        trip          = strobe && rep_match && (rep_inc >= REP_MAX) && !health_fail_q;
        last_d        = strobe ? s2_q : last_q;
        rep_cnt_d     = rep_cnt_q;
        if (strobe) begin
            if (!rep_match) begin
                rep_cnt_d = REP_W'(1);
            end else if (rep_cnt_q != REP_MAX) begin
                rep_cnt_d = rep_inc;
            end
        end
        health_fail_d = health_fail_q | trip;

        vn_act = strobe && !health_fail_q && !trip;
        emit   = vn_act && pend_q && (b0_q != s2_q);
        pend_d = pend_q;
        b0_d   = b0_q;
        if (!en) begin
            pend_d = 1'b0;
        end else if (vn_act) begin
            if (!pend_q) begin
                b0_d   = s2_q;
                pend_d = 1'b1;
            end else begin
                pend_d = 1'b0;
            end
        end

        acc_full  = (bit_cnt_q == BITS_FULL);
        load      = acc_full && !health_fail_q && !trip && (!rnd_valid_q || rnd_ready);
        acc_d     = acc_q;
        bit_cnt_d = bit_cnt_q;
        if (load) begin
            bit_cnt_d = '0;
        end else if (emit && !acc_full) begin
            // A "10" pair emits 1 and "01" emits 0, i.e. the first bit of the pair.
            for (int i = 0; i < WORD_W; i++) begin
                if (bit_cnt_q == BIT_W'(i)) acc_d[i] = b0_q;
            end
            bit_cnt_d = bit_cnt_q + 1'b1;
        end

        rnd_data_d  = rnd_data_q;
        rnd_valid_d = rnd_valid_q;
        if (load) begin
            rnd_data_d  = acc_q;
            rnd_valid_d = 1'b1;
        end else if (rnd_valid_q && rnd_ready) begin
            rnd_valid_d = 1'b0;
        end

        if (trip) begin
            rnd_valid_d = 1'b0;
            bit_cnt_d   = '0;
            pend_d      = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge value of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q          <= 1'b0;
            s2_q          <= 1'b0;
            div_cnt_q     <= '0;
            pend_q        <= 1'b0;
            b0_q          <= 1'b0;
            bit_cnt_q     <= '0;
            acc_q         <= '0;
            last_q        <= 1'b0;
            rep_cnt_q     <= '0;
            health_fail_q <= 1'b0;
            rnd_data_q    <= '0;
            rnd_valid_q   <= 1'b0;
        end else begin
            s1_q          <= raw_bit;
            s2_q          <= s1_q;
            div_cnt_q     <= div_cnt_d;
            pend_q        <= pend_d;
            b0_q          <= b0_d;
            bit_cnt_q     <= bit_cnt_d;
            acc_q         <= acc_d;
            last_q        <= last_d;
            rep_cnt_q     <= rep_cnt_d;
            health_fail_q <= health_fail_d;
            rnd_data_q    <= rnd_data_d;
            rnd_valid_q   <= rnd_valid_d;
        end
    end

    assign rnd_data    = rnd_data_q;
    assign rnd_valid   = rnd_valid_q;
    assign health_fail = health_fail_q;

endmodule

// File: tb/tb_trng_postproc.sv
// Bench for trng_postproc: table-driven raw-bit streams with a word scoreboard,
// plus hand sequences for back-pressure, RCT trip, decimation and reset.
module tb_trng_postproc;

    logic       clk = 1'b0;
    logic       rst;
    logic       raw_bit, en, rnd_ready;
    logic [7:0] rnd_data;
    logic       rnd_valid, health_fail;
    logic       raw4, en4, ready4;
    logic [7:0] data4;
    logic       valid4, fail4;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] exp_q[$];

    typedef struct {
        logic [63:0] bits;    // bit 0 is sent first
        int          n;
        logic [7:0]  word;
        bit          appears; // word is expected to leave the DUT
    } vec_t;
    vec_t vecs[5];

    trng_postproc #(.WORD_W(8), .SAMPLE_DIV(1), .RCT_CUTOFF(32)) u_dut (
        .clk(clk), .rst(rst), .raw_bit(raw_bit), .en(en),
        .rnd_data(rnd_data), .rnd_valid(rnd_valid), .rnd_ready(rnd_ready),
        .health_fail(health_fail)
    );

    trng_postproc #(.WORD_W(8), .SAMPLE_DIV(4), .RCT_CUTOFF(32)) u_dut4 (
        .clk(clk), .rst(rst), .raw_bit(raw4), .en(en4),
        .rnd_data(data4), .rnd_valid(valid4), .rnd_ready(ready4),
        .health_fail(fail4)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Raw bits are held DIV cycles each; en rises two cycles late to cover the synchroniser.
    task automatic send(input logic [63:0] bits, input int n, input bit use4);
        int div;
        int idx;
        div = use4 ? 4 : 1;
        for (int k = 0; k <= div * n + 1; k++) begin
            @(negedge clk);
            idx = k / div;
            if (idx > n - 1) idx = n - 1;
            if (use4) begin
                raw4 = bits[idx];
                en4  = (k >= 2);
            end else begin
                raw_bit = bits[idx];
                en      = (k >= 2);
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            en  = 1'b0;
            en4 = 1'b0;
        end
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst = 1'b1;
        en  = 1'b0;
        en4 = 1'b0;
        repeat (n) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_valid4(input int budget);
        for (int c = 0; c < budget && !valid4; c++) @(negedge clk);
        check("dut4_valid_in_time", valid4, 1);
    endtask

    // Scoreboard: every completed transfer on the main DUT pops one expected word.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (!rst && rnd_valid && rnd_ready) begin
                check("sb_word_expected", (exp_q.size() > 0), 1);
                if (exp_q.size() > 0) check("sb_word", rnd_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        vecs[0] = '{64'h5555,     16, 8'hFF, 1'b1};  // 10 x8
        vecs[1] = '{64'hD2D2D2D2, 32, 8'hAA, 1'b1};  // 01,00,10,11 x4
        vecs[2] = '{64'hAA55,     16, 8'h0F, 1'b1};  // 10 x4, 01 x4
        vecs[3] = '{64'hA55A,     16, 8'h3C, 1'b0};  // discarded while buffer blocked
        vecs[4] = '{64'h6AA9,     16, 8'h81, 1'b0};  // discarded while buffer blocked

        rst = 1'b1; en = 1'b0; raw_bit = 1'b0; rnd_ready = 1'b1;
        en4 = 1'b0; raw4 = 1'b0; ready4 = 1'b0;

        // Reset state of both instances
        do_reset(2);
        check("rst_data",   rnd_data, 0);
        check("rst_valid",  rnd_valid, 0);
        check("rst_health", health_fail, 0);
        check("rst4_valid", valid4, 0);
        check("rst4_health", fail4, 0);

        // Table: FF, AA with 00/11 pairs, then three words under back-pressure
        for (int i = 0; i < 5; i++) begin
            if (i == 1) rnd_ready = 1'b0;
            if (vecs[i].appears) exp_q.push_back(vecs[i].word);
            send(vecs[i].bits, vecs[i].n, 1'b0);
            idle(4);
            if (i >= 1) begin
                check("held_valid", rnd_valid, 1);
                check("held_data",  rnd_data, 8'hAA);
            end
        end
        check("no_fail_yet", health_fail, 0);

        // Release: AA then 0F back-to-back, discarded words never appear
        rnd_ready = 1'b1;
        idle(4);
        check("release_drained", exp_q.size(), 0);
        check("release_valid",   rnd_valid, 0);

        // RCT: a held word is dropped when the test trips
        rnd_ready = 1'b0;
        send(vecs[0].bits, vecs[0].n, 1'b0);
        idle(4);
        check("rct_pre_valid", rnd_valid, 1);
        check("rct_pre_data",  rnd_data, 8'hFF);
        send(64'hFFFF_FFFF_FFFF_FFFF, 31, 1'b0);
        idle(2);
        check("rct_31_health", health_fail, 0);
        check("rct_31_valid",  rnd_valid, 1);
        send(64'h1, 1, 1'b0);
        idle(2);
        check("rct_32_health", health_fail, 1);
        check("rct_32_valid",  rnd_valid, 0);
        rnd_ready = 1'b1;
        send(vecs[0].bits, vecs[0].n, 1'b0);
        idle(4);
        check("rct_sticky_health", health_fail, 1);
        check("rct_sticky_valid",  rnd_valid, 0);

        // Decimation by 4 and pend cleared by en drop mid-pair
        send(64'h5555, 16, 1'b1);
        idle(4);
        wait_valid4(50);
        check("div4_word", data4, 8'hFF);
        @(negedge clk) ready4 = 1'b1;
        @(negedge clk) ready4 = 1'b0;
        check("div4_popped", valid4, 0);
        send(64'h1, 1, 1'b1);
        idle(3);
        send(64'hAAAA, 16, 1'b1);
        idle(4);
        wait_valid4(50);
        check("div4_fresh_pair", data4, 8'h00);
        check("div4_health", fail4, 0);

        // Reset clears sticky failure, then mid-word reset with a held word
        do_reset(2);
        check("rst2_health", health_fail, 0);
        rnd_ready = 1'b0;
        send(vecs[4].bits, vecs[4].n, 1'b0);
        send(vecs[2].bits, 8, 1'b0);
        idle(2);
        check("midword_valid", rnd_valid, 1);
        check("midword_data",  rnd_data, 8'h81);
        do_reset(1);
        check("rst3_valid",  rnd_valid, 0);
        check("rst3_data",   rnd_data, 0);
        check("rst3_health", health_fail, 0);
        rnd_ready = 1'b1;
        exp_q.push_back(8'h3C);
        send(vecs[3].bits, vecs[3].n, 1'b0);
        idle(6);
        check("post_reset_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
